// File: rtl/wb_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter_if
//  Description : Bundle of FU result inputs and writeback outputs for wb_arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface wb_arbiter_if #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4
);
    localparam int c_grant_w = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;

    // FU result side
    logic [FU_COUNT-1:0]                                  fu_out_valid;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0]                fu_out_inst_id;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][PRN_BITS-1:0]  fu_out_prn;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0][63:0]          fu_out_data;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]                fu_out_data_valid;
    logic [FU_COUNT-1:0]                                  fu_ready;

    // Writeback side
    logic                                    rob_ready;
    logic [MAX_OPERANDS-1:0]                 prf_write_enable;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   prf_write_prn;
    logic [MAX_OPERANDS-1:0][63:0]           prf_write_data;
    logic [MAX_OPERANDS-1:0]                 set_prn_ready;
    logic [MAX_OPERANDS-1:0][PRN_BITS-1:0]   set_prn;
    logic                                    rob_done_valid;
    logic [INST_ID_BITS-1:0]                 rob_done_inst_id;
    logic [c_grant_w-1:0]                    grant_fu;
    logic                                    overflow_err;

    modport slave (
        input  fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        input  rob_ready,
        output fu_ready,
        output prf_write_enable, prf_write_prn, prf_write_data,
        output set_prn_ready, set_prn,
        output rob_done_valid, rob_done_inst_id, grant_fu, overflow_err
    );

    modport master (
        output fu_out_valid, fu_out_inst_id, fu_out_prn, fu_out_data, fu_out_data_valid,
        output rob_ready,
        input  fu_ready,
        input  prf_write_enable, prf_write_prn, prf_write_data,
        input  set_prn_ready, set_prn,
        input  rob_done_valid, rob_done_inst_id, grant_fu, overflow_err
    );
endinterface
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : wb_arbiter
//  Description : Per-FU result FIFOs with round-robin grant onto the single
//                PRF write / ROB completion / wakeup broadcast path.
//                Optional macro WB_BYPASS_EN: same-cycle forward of an
//                incoming bundle when every FIFO is empty.
//  Revision    : 1.0  initial release
// ============================================================================
module wb_arbiter #(
    parameter int INST_ID_BITS = 6,
    parameter int PRN_BITS     = 6,
    parameter int MAX_OPERANDS = 3,
    parameter int FU_COUNT     = 4,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int c_grant_w = (FU_COUNT > 1) ? $clog2(FU_COUNT) : 1;
    localparam int c_ptr_w   = $clog2(FIFO_DEPTH);
    localparam int c_cnt_w   = $clog2(FIFO_DEPTH + 1);

    typedef logic [MAX_OPERANDS-1:0][PRN_BITS-1:0] prn_vec_t;
    typedef logic [MAX_OPERANDS-1:0][63:0]         data_vec_t;

    logic [FU_COUNT-1:0]                    w_nonempty;
    logic [FU_COUNT-1:0]                    w_pop;
    logic [FU_COUNT-1:0]                    w_push_req;
    logic [FU_COUNT-1:0]                    w_ovf;
    logic [FU_COUNT-1:0][INST_ID_BITS-1:0]  w_head_id;
    prn_vec_t  [FU_COUNT-1:0]               w_head_prn;
    data_vec_t [FU_COUNT-1:0]               w_head_data;
    logic [FU_COUNT-1:0][MAX_OPERANDS-1:0]  w_head_dv;

    logic [c_grant_w-1:0] r_rr;
    logic [c_grant_w-1:0] w_win;
    logic [c_grant_w-1:0] w_adv_fu;
    logic                 w_found;
    logic                 w_grant;
    logic                 w_bypass;
    logic                 w_adv;
    logic                 r_overflow;

    // (base + off) mod FU_COUNT, valid for base < FU_COUNT and off <= FU_COUNT
    function automatic logic [c_grant_w-1:0] f_rr_add(input logic [c_grant_w-1:0] base,
                                                      input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= FU_COUNT) sum = sum - FU_COUNT;
        return c_grant_w'(sum);
    endfunction

    // ------------------------------------------------------------------
    // Round-robin search over non-empty FIFOs
    // ------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = r_rr;
        for (int i = 0; i < FU_COUNT; i++) begin
            if (!w_found && w_nonempty[f_rr_add(r_rr, i)]) begin
                w_found = 1'b1;
                w_win   = f_rr_add(r_rr, i);
            end
        end
    end

    assign w_grant = bus.rob_ready & w_found;

`ifdef WB_BYPASS_EN
    logic                 w_byp_found;
    logic [c_grant_w-1:0] w_byp_win;

    always_comb begin
        w_byp_found = 1'b0;
        w_byp_win   = r_rr;
        for (int i = 0; i < FU_COUNT; i++) begin
            if (!w_byp_found && bus.fu_out_valid[f_rr_add(r_rr, i)]) begin
                w_byp_found = 1'b1;
                w_byp_win   = f_rr_add(r_rr, i);
            end
        end
    end

    // Reset gating keeps outputs quiet while rst is being sampled
    assign w_bypass = bus.rob_ready & ~rst & ~w_found & w_byp_found;
    assign w_adv_fu = w_grant ? w_win : w_byp_win;

    always_comb begin
        w_push_req = bus.fu_out_valid;
        if (w_bypass) w_push_req[w_byp_win] = 1'b0;
    end
`else
    assign w_bypass   = 1'b0;
    assign w_adv_fu   = w_win;
    assign w_push_req = bus.fu_out_valid;
`endif

    assign w_adv = w_grant | w_bypass;

    always_comb begin
        w_pop = '0;
        if (w_grant) w_pop[w_win] = 1'b1;
    end

    // ------------------------------------------------------------------
    // Per-FU result FIFOs
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < FU_COUNT; gi++) begin : g_fifo
        logic [INST_ID_BITS-1:0] r_mem_id   [FIFO_DEPTH];
        prn_vec_t                r_mem_prn  [FIFO_DEPTH];
        data_vec_t               r_mem_data [FIFO_DEPTH];
        logic [MAX_OPERANDS-1:0] r_mem_dv   [FIFO_DEPTH];
        logic [c_ptr_w-1:0]      r_head;
        logic [c_ptr_w-1:0]      r_tail;
        logic [c_cnt_w-1:0]      r_count;
        logic                    w_full;
        logic                    w_accept;

        assign w_full     = (r_count == c_cnt_w'(FIFO_DEPTH));
        // A full FIFO still accepts when its head leaves on the same edge
        assign w_accept   = w_push_req[gi] & (~w_full | w_pop[gi]);
        assign w_ovf[gi]  = w_push_req[gi] & w_full & ~w_pop[gi];
        assign w_nonempty[gi]   = (r_count != '0);
        assign bus.fu_ready[gi] = ~w_full;

        assign w_head_id[gi]   = r_mem_id[r_head];
        assign w_head_prn[gi]  = r_mem_prn[r_head];
        assign w_head_data[gi] = r_mem_data[r_head];
        assign w_head_dv[gi]   = r_mem_dv[r_head];

        always_ff @(posedge clk) begin
            if (rst) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_accept) r_tail <= r_tail + c_ptr_w'(1);
                if (w_pop[gi]) r_head <= r_head + c_ptr_w'(1);
                if (w_accept && !w_pop[gi]) begin
                    r_count <= r_count + c_cnt_w'(1);
                end else if (!w_accept && w_pop[gi]) begin
                    r_count <= r_count - c_cnt_w'(1);
                end
            end
        end

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_mem_id[r_tail]   <= bus.fu_out_inst_id[gi];
                r_mem_prn[r_tail]  <= bus.fu_out_prn[gi];
                r_mem_data[r_tail] <= bus.fu_out_data[gi];
                r_mem_dv[r_tail]   <= bus.fu_out_data_valid[gi];
            end
        end
    end

    // ------------------------------------------------------------------
    // Writeback outputs
    // ------------------------------------------------------------------
    always_comb begin
        bus.rob_done_valid   = 1'b0;
        bus.rob_done_inst_id = '0;
        bus.prf_write_enable = '0;
        bus.prf_write_prn    = '0;
        bus.prf_write_data   = '0;
        bus.grant_fu         = r_rr;
        if (w_grant) begin
            bus.rob_done_valid   = 1'b1;
            bus.rob_done_inst_id = w_head_id[w_win];
            bus.prf_write_enable = w_head_dv[w_win];
            bus.prf_write_prn    = w_head_prn[w_win];
            bus.prf_write_data   = w_head_data[w_win];
            bus.grant_fu         = w_win;
        end
`ifdef WB_BYPASS_EN
        else if (w_bypass) begin
            bus.rob_done_valid   = 1'b1;
            bus.rob_done_inst_id = bus.fu_out_inst_id[w_byp_win];
            bus.prf_write_enable = bus.fu_out_data_valid[w_byp_win];
            bus.prf_write_prn    = bus.fu_out_prn[w_byp_win];
            bus.prf_write_data   = bus.fu_out_data[w_byp_win];
            bus.grant_fu         = w_byp_win;
        end
`endif
    end

    assign bus.set_prn_ready = bus.prf_write_enable;
    assign bus.set_prn       = bus.prf_write_prn;
    assign bus.overflow_err  = r_overflow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr       <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_adv) r_rr <= f_rr_add(w_adv_fu, 1);
            if (|w_ovf) r_overflow <= 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_arbiter
//  Description : Directed plus randomized bench for wb_arbiter against a
//                queue-based reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_wb_arbiter;
    localparam int c_fu    = 4;
    localparam int c_depth = 4;

    typedef struct packed {
        logic [5:0]        id;
        logic [2:0][5:0]   prn;
        logic [2:0][63:0]  data;
        logic [2:0]        dv;
    } bundle_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    bundle_t m_q [c_fu][$];
    int      m_rr = 0;
    bit      m_ovf = 1'b0;
    bit      m_exp_valid;
    bit      m_from_q;
    int      m_win;
    bundle_t m_exp;

    always #5 clk = ~clk;

    wb_arbiter_if #(.INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3), .FU_COUNT(c_fu)) bus ();

    wb_arbiter #(
        .INST_ID_BITS(6), .PRN_BITS(6), .MAX_OPERANDS(3),
        .FU_COUNT(c_fu), .FIFO_DEPTH(c_depth)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bundle_t in_bundle(input int f);
        bundle_t b;
        b.id   = bus.fu_out_inst_id[f];
        b.prn  = bus.fu_out_prn[f];
        b.data = bus.fu_out_data[f];
        b.dv   = bus.fu_out_data_valid[f];
        return b;
    endfunction

    task automatic clr_in();
        bus.fu_out_valid      = '0;
        bus.fu_out_inst_id    = '0;
        bus.fu_out_prn        = '0;
        bus.fu_out_data       = '0;
        bus.fu_out_data_valid = '0;
    endtask

    task automatic put(input int f, input logic [5:0] id,
                       input logic [5:0] p0, input logic [5:0] p1, input logic [5:0] p2,
                       input logic [63:0] d0, input logic [63:0] d1, input logic [63:0] d2,
                       input logic [2:0] dv);
        bus.fu_out_valid[f]      = 1'b1;
        bus.fu_out_inst_id[f]    = id;
        bus.fu_out_prn[f][0]     = p0;
        bus.fu_out_prn[f][1]     = p1;
        bus.fu_out_prn[f][2]     = p2;
        bus.fu_out_data[f][0]    = d0;
        bus.fu_out_data[f][1]    = d1;
        bus.fu_out_data[f][2]    = d2;
        bus.fu_out_data_valid[f] = dv;
    endtask

    task automatic put_rand(input int f, input logic [5:0] id);
        put(f, id, 6'($urandom), 6'($urandom), 6'($urandom),
            {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 3'($urandom));
    endtask

    // Predict this cycle's writeback from the model and compare all outputs
    task automatic eval();
        logic [3:0] er;
        #1;
        m_exp_valid = 1'b0;
        m_from_q    = 1'b0;
        m_win       = m_rr;
        if (bus.rob_ready && !rst) begin
            for (int i = 0; i < c_fu; i++) begin
                int f;
                f = (m_rr + i) % c_fu;
                if (!m_exp_valid && m_q[f].size() != 0) begin
                    m_exp_valid = 1'b1;
                    m_from_q    = 1'b1;
                    m_win       = f;
                    m_exp       = m_q[f][0];
                end
            end
`ifdef WB_BYPASS_EN
            for (int i = 0; i < c_fu; i++) begin
                int f;
                f = (m_rr + i) % c_fu;
                if (!m_exp_valid && bus.fu_out_valid[f]) begin
                    m_exp_valid = 1'b1;
                    m_win       = f;
                    m_exp       = in_bundle(f);
                end
            end
`endif
        end
        for (int f = 0; f < c_fu; f++) er[f] = (m_q[f].size() < c_depth);
        if (!rst) begin
            chk("rob_done_valid", 256'(bus.rob_done_valid), 256'(m_exp_valid));
            chk("grant_fu", 256'(bus.grant_fu), 256'(m_win));
            chk("prf_write_enable", 256'(bus.prf_write_enable), 256'(m_exp_valid ? m_exp.dv : 3'b0));
            chk("set_prn_ready", 256'(bus.set_prn_ready), 256'(m_exp_valid ? m_exp.dv : 3'b0));
            chk("fu_ready", 256'(bus.fu_ready), 256'(er));
            chk("overflow_err", 256'(bus.overflow_err), 256'(m_ovf));
            if (m_exp_valid) begin
                chk("rob_done_inst_id", 256'(bus.rob_done_inst_id), 256'(m_exp.id));
                chk("prf_write_prn", 256'(bus.prf_write_prn), 256'(m_exp.prn));
                chk("set_prn", 256'(bus.set_prn), 256'(m_exp.prn));
                chk("prf_write_data", 256'(bus.prf_write_data), 256'(m_exp.data));
            end
        end
    endtask

    // Apply this cycle's pop/push to the model, then move to the next cycle
    task automatic adv();
        if (rst) begin
            for (int f = 0; f < c_fu; f++) m_q[f].delete();
            m_rr  = 0;
            m_ovf = 1'b0;
        end else begin
            if (m_exp_valid) begin
                if (m_from_q) void'(m_q[m_win].pop_front());
                m_rr = (m_win + 1) % c_fu;
            end
            for (int f = 0; f < c_fu; f++) begin
                if (bus.fu_out_valid[f] && !(m_exp_valid && !m_from_q && m_win == f)) begin
                    if (m_q[f].size() < c_depth) m_q[f].push_back(in_bundle(f));
                    else m_ovf = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cyc();
        eval();
        adv();
    endtask

    task automatic do_reset();
        clr_in();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_valid"}, 256'(bus.rob_done_valid), 256'(0));
        chk({tag, "_we"}, 256'(bus.prf_write_enable), 256'(0));
        chk({tag, "_prn"}, 256'(bus.prf_write_prn), 256'(0));
        chk({tag, "_data"}, 256'(bus.prf_write_data), 256'(0));
        chk({tag, "_id"}, 256'(bus.rob_done_inst_id), 256'(0));
        chk({tag, "_grant"}, 256'(bus.grant_fu), 256'(0));
        chk({tag, "_ready"}, 256'(bus.fu_ready), 256'(4'hf));
        chk({tag, "_ovf"}, 256'(bus.overflow_err), 256'(0));
    endtask

    initial begin
        bus.rob_ready = 1'b0;
        do_reset();

        // Reset state
        eval();
        chk_quiet("reset");
        adv();

        // Single bundle on FU1
        bus.rob_ready = 1'b1;
        put(1, 6'd5, 6'd3, 6'd7, 6'd0, 64'hA, 64'hB, 64'h0, 3'b011);
        eval();
`ifndef WB_BYPASS_EN
        chk("push_cycle_quiet", 256'(bus.rob_done_valid), 256'(0));
`endif
        adv();
        clr_in();
        eval();
`ifndef WB_BYPASS_EN
        chk("single_valid", 256'(bus.rob_done_valid), 256'(1));
        chk("single_id", 256'(bus.rob_done_inst_id), 256'(5));
        chk("single_grant", 256'(bus.grant_fu), 256'(1));
        chk("single_we", 256'(bus.prf_write_enable), 256'(3'b011));
        chk("single_prn0", 256'(bus.set_prn[0]), 256'(3));
        chk("single_prn1", 256'(bus.set_prn[1]), 256'(7));
        chk("single_data1", 256'(bus.prf_write_data[1]), 256'(64'hB));
`endif
        adv();

        // All four FUs push together
        do_reset();
        bus.rob_ready = 1'b1;
        for (int f = 0; f < c_fu; f++) put_rand(f, 6'(10 + f));
        cyc();
        clr_in();
        for (int k = 0; k < c_fu; k++) begin
            eval();
`ifndef WB_BYPASS_EN
            chk("rr_grant", 256'(bus.grant_fu), 256'(k));
            chk("rr_id", 256'(bus.rob_done_inst_id), 256'(10 + k));
`endif
            adv();
        end

        // Backpressure and overflow on FU2
        do_reset();
        bus.rob_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clr_in();
            put_rand(2, 6'(20 + k));
            cyc();
        end
        clr_in();
        eval();
        chk("bp_ready2", 256'(bus.fu_ready[2]), 256'(0));
        chk("bp_no_ovf_yet", 256'(bus.overflow_err), 256'(0));
        adv();
        put_rand(2, 6'd24);
        cyc();
        clr_in();
        eval();
        chk("bp_ovf", 256'(bus.overflow_err), 256'(1));
        adv();
        bus.rob_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            eval();
            chk("bp_drain_id", 256'(bus.rob_done_inst_id), 256'(20 + k));
            chk("bp_drain_grant", 256'(bus.grant_fu), 256'(2));
            adv();
        end
        eval();
        chk("bp_dropped_absent", 256'(bus.rob_done_valid), 256'(0));
        adv();

        // Full FIFO0 with simultaneous push and pop
        do_reset();
        bus.rob_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            clr_in();
            put_rand(0, 6'(30 + k));
            cyc();
        end
        clr_in();
        bus.rob_ready = 1'b1;
        put_rand(0, 6'd34);
        eval();
        chk("full_pp_id", 256'(bus.rob_done_inst_id), 256'(30));
        adv();
        clr_in();
        for (int k = 1; k < 5; k++) begin
            eval();
            if (k == 1) begin
                chk("full_pp_ready0", 256'(bus.fu_ready[0]), 256'(0));
                chk("full_pp_no_ovf", 256'(bus.overflow_err), 256'(0));
            end
            chk("full_pp_drain", 256'(bus.rob_done_inst_id), 256'(30 + k));
            adv();
        end

        // Reset while draining
        do_reset();
        bus.rob_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            clr_in();
            put_rand(1, 6'(40 + k));
            cyc();
        end
        clr_in();
        bus.rob_ready = 1'b1;
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        eval();
        chk_quiet("mid_reset");
        adv();
        for (int k = 0; k < 3; k++) begin
            eval();
            chk("no_stale", 256'(bus.rob_done_valid), 256'(0));
            adv();
        end

`ifdef WB_BYPASS_EN
        // Same-cycle forward when every FIFO is empty
        do_reset();
        bus.rob_ready = 1'b1;
        put_rand(3, 6'd9);
        eval();
        chk("byp_valid", 256'(bus.rob_done_valid), 256'(1));
        chk("byp_id", 256'(bus.rob_done_inst_id), 256'(9));
        chk("byp_grant", 256'(bus.grant_fu), 256'(3));
        adv();
        clr_in();
        eval();
        chk("byp_not_pushed", 256'(bus.fu_ready[3]), 256'(1));
        chk("byp_no_repeat", 256'(bus.rob_done_valid), 256'(0));
        adv();
`endif

        // Randomized traffic with light and heavy phases
        do_reset();
        for (int n = 0; n < 600; n++) begin
            int load;
            load = ((n / 100) % 2 == 1) ? 5 : 2;
            clr_in();
            bus.rob_ready = ($urandom_range(0, 9) < 7);
            for (int f = 0; f < c_fu; f++) begin
                if ($urandom_range(0, 9) < load) put_rand(f, 6'($urandom));
            end
            rst = ($urandom_range(0, 149) == 0);
            cyc();
            rst = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
